// File: rtl/digit_scan_capture.sv
// digit_scan_capture: samples a multiplexed 4-digit 7-segment scan
// and recovers the hex value shown on each digit position.
module digit_scan_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 300000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] An_n,
    input  logic [6:0] Seg_n,
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic       Valid,
    output logic       Frame_done,
    output logic       Seg_err,
    output logic       An_err,
    output logic       Stale
);

    localparam logic [7:0]  SMAX = 8'(SETTLE);
    localparam logic [7:0]  SPRE = 8'(SETTLE - 1);
    localparam logic [19:0] TMAX = 20'(TIMEOUT);
    localparam logic [19:0] TPRE = 20'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STALE   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  an_s1, an_s2, an_p;
    logic [6:0]  seg_s1, seg_s2, seg_p;
    logic [7:0]  scnt;
    logic [19:0] tcnt;
    logic [3:0]  seen;
    logic [3:0]  digit [4];

    logic        same;
    logic        capture;
    logic [6:0]  glyph;
    logic        hit;
    logic [3:0]  hexv;
    logic [1:0]  sel;
    logic        blank;
    logic        one_low;
    logic        multi;
    logic        ok;
    logic        expire;
    logic [3:0]  new_seen;

    assign same    = {an_s2, seg_s2} == {an_p, seg_p};
    assign capture = same && (scnt == SPRE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            an_s1  <= '1;
            an_s2  <= '1;
            an_p   <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_p  <= '1;
            scnt   <= '0;
        end else begin
            an_s1  <= An_n;
            an_s2  <= an_s1;
            an_p   <= an_s2;
            seg_s1 <= Seg_n;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            if (!same)
                scnt <= '0;
            else if (scnt != SMAX)
                scnt <= scnt + 8'd1;
        end
    end

    // Active-high abcdefg pattern matched against the hex glyph set
    always_comb begin
        glyph = ~seg_s2;
        hit   = 1'b1;
        hexv  = 4'h0;
        case (glyph)
            7'h3F: hexv = 4'h0;
            7'h06: hexv = 4'h1;
            7'h5B: hexv = 4'h2;
            7'h4F: hexv = 4'h3;
            7'h66: hexv = 4'h4;
            7'h6D: hexv = 4'h5;
            7'h7D: hexv = 4'h6;
            7'h07: hexv = 4'h7;
            7'h7F: hexv = 4'h8;
            7'h6F: hexv = 4'h9;
            7'h77: hexv = 4'hA;
            7'h7C: hexv = 4'hB;
            7'h39: hexv = 4'hC;
            7'h5E: hexv = 4'hD;
            7'h79: hexv = 4'hE;
            7'h71: hexv = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        sel = 2'd3;
        case (an_s2)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            default: sel = 2'd3;
        endcase
    end

    assign blank    = an_s2 == 4'hF;
    assign one_low  = $countones(~an_s2) == 1;
    assign multi    = !blank && !one_low;
    assign ok       = capture && one_low && hit;
    assign expire   = (tcnt == TPRE) && !ok;
    assign new_seen = seen | (4'b0001 << sel);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            seen       <= '0;
            Valid      <= 1'b0;
            Frame_done <= 1'b0;
            Seg_err    <= 1'b0;
            An_err     <= 1'b0;
            for (int i = 0; i < 4; i++)
                digit[i] <= '0;
        end else begin
            Frame_done <= 1'b0;
            Seg_err    <= capture && one_low && !hit;
            An_err     <= capture && multi;
            if (ok)
                tcnt <= '0;
            else if (tcnt != TMAX)
                tcnt <= tcnt + 20'd1;
            // A capture on the expiry edge wins over going stale
            if (ok) begin
                digit[sel] <= hexv;
                state      <= COLLECT;
                if (new_seen == 4'hF) begin
                    seen       <= '0;
                    Valid      <= 1'b1;
                    Frame_done <= 1'b1;
                end else begin
                    seen <= new_seen;
                end
            end else if (expire) begin
                state <= STALE;
                Valid <= 1'b0;
                seen  <= '0;
            end
        end
    end

    assign Stale  = state == STALE;
    assign Digit0 = digit[0];
    assign Digit1 = digit[1];
    assign Digit2 = digit[2];
    assign Digit3 = digit[3];

endmodule

// File: tb/tb_digit_scan_capture.sv
// tb_digit_scan_capture: directed scans plus random anode/segment
// traffic compared each cycle against a behavioural frame model.
module tb_digit_scan_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 600;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic [3:0] An_n    = 4'hF;
    logic [6:0] Seg_n   = 7'h7F;
    logic [3:0] Digit0, Digit1, Digit2, Digit3;
    logic       Valid, Frame_done, Seg_err, An_err, Stale;

    digit_scan_capture #(
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .An_n      (An_n),
        .Seg_n     (Seg_n),
        .Digit0    (Digit0),
        .Digit1    (Digit1),
        .Digit2    (Digit2),
        .Digit3    (Digit3),
        .Valid     (Valid),
        .Frame_done(Frame_done),
        .Seg_err   (Seg_err),
        .An_err    (An_err),
        .Stale     (Stale)
    );

    always #5 Clock = ~Clock;

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int checks = 0;
    int errors = 0;
    int tk, tk_fd, fd_cnt, se_cnt, ae_cnt, d0_one;

    logic [10:0] last_x, pipe0, pipe1;
    logic        ev0, ev1;
    int          run, cyc, last_ok;
    logic [3:0]  m_digit [4];
    logic [3:0]  m_seen;
    logic        m_valid, m_stale, m_fd, m_se, m_ae;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        last_x  = 11'h7FF;
        pipe0   = 11'h7FF;
        pipe1   = 11'h7FF;
        ev0     = 1'b0;
        ev1     = 1'b0;
        run     = 1;
        cyc     = 0;
        last_ok = 0;
        m_seen  = 4'h0;
        m_valid = 1'b0;
        m_stale = 1'b0;
        m_fd    = 1'b0;
        m_se    = 1'b0;
        m_ae    = 1'b0;
        for (int i = 0; i < 4; i++)
            m_digit[i] = 4'h0;
    endtask

    // A pattern sampled unchanged SETTLE+1 times is acted on two edges later
    task automatic m_step();
        logic [10:0] x, p;
        logic        mat, ok;
        int          zeros, k, g;
        x     = {An_n, Seg_n};
        mat   = ev1;
        p     = pipe1;
        ev1   = ev0;
        pipe1 = pipe0;
        run   = (x == last_x) ? run + 1 : 1;
        last_x = x;
        ev0   = (run == SETTLE + 1);
        pipe0 = x;
        cyc++;
        m_fd = 1'b0;
        m_se = 1'b0;
        m_ae = 1'b0;
        ok   = 1'b0;
        if (mat) begin
            zeros = $countones(~p[10:7]);
            if (zeros == 1) begin
                k = 0;
                for (int i = 0; i < 4; i++)
                    if (!p[7+i]) k = i;
                g = -1;
                for (int i = 0; i < 16; i++)
                    if (glyph_tab[i] == ~p[6:0]) g = i;
                if (g >= 0) begin
                    ok = 1'b1;
                    last_ok = cyc;
                    m_stale = 1'b0;
                    m_digit[k] = 4'(g);
                    m_seen[k] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_fd = 1'b1;
                        m_seen = 4'h0;
                        m_valid = 1'b1;
                    end
                end else begin
                    m_se = 1'b1;
                end
            end else if (zeros > 1) begin
                m_ae = 1'b1;
            end
        end
        if (!ok && (cyc - last_ok == TIMEOUT)) begin
            m_stale = 1'b1;
            m_valid = 1'b0;
            m_seen = 4'h0;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset_n) m_step();
        @(negedge Clock);
        tk++;
        if (Reset_n) begin
            chk("outs",
                {Digit3, Digit2, Digit1, Digit0, Valid, Stale,
                 Frame_done, Seg_err, An_err},
                {m_digit[3], m_digit[2], m_digit[1], m_digit[0],
                 m_valid, m_stale, m_fd, m_se, m_ae});
            fd_cnt += int'(Frame_done);
            se_cnt += int'(Seg_err);
            ae_cnt += int'(An_err);
            if (Digit0 == 4'h1) d0_one++;
            if (Frame_done) tk_fd = tk;
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg,
                        input int n);
        An_n  = an;
        Seg_n = seg;
        repeat (n) tick();
    endtask

    task automatic clr();
        fd_cnt = 0;
        se_cnt = 0;
        ae_cnt = 0;
        d0_one = 0;
    endtask

    task automatic do_reset(input int n);
        Reset_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst",
            {Digit3, Digit2, Digit1, Digit0, Valid, Stale,
             Frame_done, Seg_err, An_err}, 32'h0);
        An_n  = 4'hF;
        Seg_n = 7'h7F;
        repeat (n) tick();
        Reset_n = 1'b1;
    endtask

    initial begin
        int w;
        logic [3:0] an;
        logic [6:0] seg;
        m_reset();
        tk = 0;
        tk_fd = 0;
        clr();
        repeat (3) tick();
        chk("rst_state",
            {Digit3, Digit2, Digit1, Digit0, Valid, Stale,
             Frame_done, Seg_err, An_err}, 32'h0);
        Reset_n = 1'b1;
        hold(4'hF, 7'h7F, 5);

        clr();
        hold(4'hE, ~7'h3F, 40);
        hold(4'hD, ~7'h06, 40);
        hold(4'hB, ~7'h5B, 40);
        hold(4'h7, ~7'h4F, 40);
        chk("scan_digits", {Digit3, Digit2, Digit1, Digit0}, 32'h3210);
        chk("scan_fd", fd_cnt, 1);
        chk("scan_valid", Valid, 1);

        clr();
        hold(4'hD, ~7'h7F, 1000);
        chk("hold_d1", Digit1, 8);
        chk("hold_pulses", fd_cnt + se_cnt + ae_cnt, 0);

        clr();
        hold(4'hE, ~7'h06, SETTLE - 1);
        hold(4'hE, ~7'h5B, 40);
        chk("glitch_d0", Digit0, 2);
        chk("glitch_seen", d0_one, 0);

        clr();
        hold(4'hC, ~7'h3F, 40);
        chk("an_err", ae_cnt, 1);
        chk("an_err_excl", se_cnt, 0);
        clr();
        hold(4'hE, ~7'h00, 40);
        chk("seg_err", se_cnt, 1);
        chk("seg_err_d0", Digit0, 2);
        clr();
        hold(4'hF, ~7'h3F, 40);
        chk("blank_pulses", fd_cnt + se_cnt + ae_cnt, 0);

        hold(4'hD, ~7'h4F, 40);
        hold(4'hB, ~7'h66, 40);
        do_reset(3);
        hold(4'hF, 7'h7F, 5);
        clr();
        hold(4'hE, ~7'h77, 40);
        hold(4'hD, ~7'h7C, 40);
        hold(4'hB, ~7'h39, 40);
        hold(4'h7, ~7'h5E, 40);
        chk("rst_fd", fd_cnt, 1);
        chk("rst_digits", {Digit3, Digit2, Digit1, Digit0}, 32'hDCBA);
        chk("rst_valid", Valid, 1);

        An_n  = 4'hF;
        Seg_n = 7'h7F;
        w = 0;
        while (Stale !== 1'b1 && w < TIMEOUT + 50) begin
            tick();
            w++;
        end
        chk("stale_delay", tk - tk_fd, TIMEOUT);
        chk("stale_valid", Valid, 0);
        chk("stale_digits", {Digit3, Digit2, Digit1, Digit0}, 32'hDCBA);
        hold(4'hB, ~7'h4F, 40);
        chk("stale_clear", Stale, 0);

        repeat (150) begin
            case ($urandom_range(0, 9))
                7:       an = 4'hF;
                8, 9:    an = 4'($urandom);
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 4) != 0)
                seg = ~glyph_tab[$urandom_range(0, 15)];
            else
                seg = 7'($urandom);
            hold(an, seg, $urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
